// File: rtl/ps2_kbd_tx.sv
// PS/2 keyboard-side transmitter. It queues scan-code bytes in a small FIFO and
// serialises each one as an 11-bit frame: start, data LSB first, odd parity, stop.
module ps2_kbd_tx #(
  parameter int CLK_DIV    = 16,
  parameter int AW         = 3,
  parameter int GAP_HALVES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       inject_parity_err,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] sent_cnt
);
  localparam int DEPTH   = 1 << AW;
  localparam int GAP_CYC = GAP_HALVES * CLK_DIV;
  localparam int DMAX    = (GAP_CYC > CLK_DIV) ? GAP_CYC : CLK_DIV;
  localparam int DW      = $clog2(DMAX + 1);

  localparam logic [AW:0]   FULL     = (AW+1)'(DEPTH);
  localparam logic [DW-1:0] HALF_END = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] GAP_END  = DW'(GAP_CYC - 1);
  localparam logic [3:0]    LAST_BIT = 4'd10;

  typedef enum logic [1:0] {IDLE, SETUP, LOW, GAP} state_t;
  state_t state, next_state;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop;
  logic [7:0]    head;
  logic          par;

  logic [DW-1:0] div;
  logic [3:0]    idx;
  logic [10:0]   frame;
  logic          div_clr, idx_inc, load, done;

  assign in_ready = (count != FULL);
  assign push     = in_valid & in_ready;
  assign pop      = load;
  assign busy     = (state != IDLE) | (count != '0);

  assign head = mem[rd_ptr];
  assign par  = ~^head ^ inject_parity_err;

  // FIFO storage needs no reset; only pointers and count carry state
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    div_clr    = 1'b0;
    idx_inc    = 1'b0;
    load       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        div_clr = 1'b1;
        if (count != '0) begin
          load       = 1'b1;
          next_state = SETUP;
        end
      end
      SETUP: begin
        if (div == HALF_END) begin
          div_clr    = 1'b1;
          next_state = LOW;
        end
      end
      LOW: begin
        if (div == HALF_END) begin
          div_clr = 1'b1;
          if (idx == LAST_BIT) begin
            done       = 1'b1;
            next_state = GAP;
          end else begin
            idx_inc    = 1'b1;
            next_state = SETUP;
          end
        end
      end
      GAP: begin
        if (div == GAP_END) begin
          div_clr    = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div        <= '0;
      idx        <= '0;
      frame      <= '1;
      frame_done <= 1'b0;
      sent_cnt   <= '0;
    end else begin
      div        <= div_clr ? '0 : div + 1'b1;
      frame_done <= done;
      if (done) sent_cnt <= sent_cnt + 1'b1;
      if (load) begin
        idx   <= '0;
        frame <= {1'b1, par, head, 1'b0};
      end else if (idx_inc) begin
        idx <= idx + 1'b1;
      end
    end
  end

  // Lines are registered from the current state, so they lag it by one cycle;
  // data settles while ps2_clk is high, a half-period before each falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps2_clk  <= 1'b1;
      ps2_data <= 1'b1;
    end else begin
      ps2_clk  <= (state != LOW);
      ps2_data <= (state == SETUP || state == LOW) ? frame[idx] : 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Bench for ps2_kbd_tx: the driver queues expected frames and a line monitor decodes
// ps2_clk/ps2_data on its own, comparing each frame with the scoreboard.
module tb_ps2_kbd_tx;
  localparam int CLK_DIV    = 4;
  localparam int AW         = 3;
  localparam int GAP_HALVES = 4;
  localparam int GAP_CYC    = GAP_HALVES * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       inject_parity_err = 1'b0;
  logic       in_ready, ps2_clk, ps2_data, busy, frame_done;
  logic [7:0] sent_cnt;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ps2_kbd_tx #(.CLK_DIV(CLK_DIV), .AW(AW), .GAP_HALVES(GAP_HALVES)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .inject_parity_err(inject_parity_err), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .busy(busy), .frame_done(frame_done), .sent_cnt(sent_cnt)
  );

  logic [10:0] exp_q[$];

  // Frame as the wire should carry it, index 0 first on the line.
  function automatic logic [10:0] frame_of(input logic [7:0] d, input logic inj);
    logic p;
    p = (($countones(d) % 2) == 0) ^ inj;
    return {1'b1, p, d, 1'b0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- line monitor / scoreboard consumer ----------------
  logic        pc_prev = 1'b1, pd_prev = 1'b1, fd_prev = 1'b0;
  int          nb = 0, rx_frames = 0, fd_count = 0;
  int          start_cyc = 0, fall_cyc = 0, rise_cyc = 0;
  bit          frame_end = 0, have_rise = 0, tight = 0;
  logic [10:0] sh;

  always @(negedge clk) begin
    if (rst) begin
      nb = 0; rx_frames = 0; exp_q.delete();
      frame_end = 0; have_rise = 0;
      pc_prev = 1'b1; pd_prev = 1'b1; fd_prev = 1'b0;
    end else begin
      if (!ps2_clk && !pc_prev) chk("data_stable_clk_low", ps2_data, pd_prev);
      if (pd_prev && !ps2_data && ps2_clk && nb == 0) begin
        start_cyc = cyc;
        if (have_rise) begin
          if (tight) chk("gap_back_to_back", cyc - rise_cyc, GAP_CYC + 1);
          else       chk("gap_minimum", (cyc - rise_cyc) >= GAP_CYC + 1, 1);
          have_rise = 0;
        end
      end
      if (pc_prev && !ps2_clk) begin
        sh[nb] = ps2_data;
        if (nb == 0) chk("first_fall_delay", cyc - start_cyc, CLK_DIV);
        else         chk("fall_spacing", cyc - fall_cyc, 2 * CLK_DIV);
        fall_cyc = cyc;
        nb++;
        if (nb == 11) begin
          nb = 0;
          rx_frames++;
          frame_end = 1;
          chk("frame_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) chk("frame_bits", sh, exp_q.pop_front());
        end
      end
      if (!pc_prev && ps2_clk && frame_end) begin
        rise_cyc  = cyc;
        have_rise = 1;
        tight     = (exp_q.size() > 0);
        frame_end = 0;
      end
      if (frame_done) begin
        fd_count++;
        chk("sent_cnt_at_done", sent_cnt, rx_frames[7:0]);
        chk("frame_done_one_cycle", fd_prev, 0);
      end
      pc_prev = ps2_clk;
      pd_prev = ps2_data;
      fd_prev = frame_done;
    end
  end

  // ---------------- stimulus ----------------
  task automatic push(input logic [7:0] d);
    int t = 0;
    @(negedge clk);
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && t < 5000) begin @(negedge clk); t++; end
    if (!in_ready) begin
      chk("push_ready_timeout", in_ready, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    exp_q.push_back(frame_of(d, 1'b0));
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    int t = 0;
    while (busy && t < lim) begin @(negedge clk); t++; end
    chk("drain_busy", busy, 0);
    repeat (2) @(negedge clk);
    chk("drain_queue", exp_q.size(), 0);
  endtask

  logic [7:0] fill [12] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
                            8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};

  initial begin
    int t, dfall, cfall, i, fd0;
    bit saw_full;
    logic r;

    rst = 1'b1;
    #12;
    chk("rst_ps2_clk", ps2_clk, 1);
    chk("rst_ps2_data", ps2_data, 1);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_sent_cnt", sent_cnt, 0);
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);

    // single 0x1C with latency measurement
    @(negedge clk); in_data = 8'h1C; in_valid = 1'b1;
    @(posedge clk); exp_q.push_back(frame_of(8'h1C, 1'b0));
    #1 in_valid = 1'b0;
    t = 0; dfall = -1; cfall = -1;
    while (cfall < 0 && t < 100) begin
      @(posedge clk); t++; #1;
      if (dfall < 0 && !ps2_data) dfall = t;
      if (!ps2_clk) cfall = t;
    end
    chk("latency_start_bit", dfall, 2);
    chk("latency_first_fall", cfall, 2 + CLK_DIV);
    wait_idle(2000);
    chk("single_sent_cnt", sent_cnt, 1);
    chk("single_done_pulses", fd_count, 1);

    // back-to-back 0xF0, 0x1C
    push(8'hF0);
    push(8'h1C);
    wait_idle(2000);
    chk("b2b_sent_cnt", sent_cnt, 3);

    // parity injection on one frame only
    @(negedge clk); in_data = 8'h1C; in_valid = 1'b1; inject_parity_err = 1'b1;
    @(posedge clk); exp_q.push_back(frame_of(8'h1C, 1'b1));
    #1 in_valid = 1'b0;
    @(posedge clk); #1 inject_parity_err = 1'b0;
    wait_idle(2000);
    push(8'h1C);
    wait_idle(2000);

    // hold in_valid with 12 bytes, FIFO fills behind the active frame
    i = 0; t = 0; saw_full = 0;
    while (i < 12 && t < 20000) begin
      @(negedge clk);
      in_data = fill[i]; in_valid = 1'b1;
      r = in_ready;
      if (!r && !saw_full) begin
        saw_full = 1;
        chk("fill_depth_at_full", i, 9);
      end
      @(posedge clk);
      if (r) begin exp_q.push_back(frame_of(fill[i], 1'b0)); i++; end
      t++;
    end
    @(negedge clk); in_valid = 1'b0;
    chk("fill_ready_dropped", saw_full, 1);
    chk("fill_all_pushed", i, 12);
    wait_idle(8000);

    // random bytes with random spacing
    for (int k = 0; k < 30; k++) begin
      push(8'($urandom));
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 150)) @(negedge clk);
    end
    wait_idle(20000);
    chk("random_sent_cnt", sent_cnt, 8'(rx_frames));

    // reset while data bit 4 is on the line
    push(8'h55);
    t = 0;
    while (nb < 5 && t < 2000) begin @(negedge clk); t++; end
    chk("reached_bit4", nb >= 5, 1);
    repeat (CLK_DIV) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_ps2_clk", ps2_clk, 1);
    chk("midrst_ps2_data", ps2_data, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_sent_cnt", sent_cnt, 0);
    chk("midrst_in_ready", in_ready, 1);
    @(negedge clk); @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    fd0 = fd_count;
    push(8'h2A);
    wait_idle(2000);
    chk("post_rst_sent_cnt", sent_cnt, 1);
    chk("post_rst_done_pulses", fd_count - fd0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
